// File: rtl/coreapb3_iaddr_pkg.sv
// Shared offsets, CTRL field positions and lane helpers for the indirect-address bank.
package coreapb3_iaddr_pkg;

    localparam logic [4:0] LANE0    = 5'h00;
    localparam logic [4:0] LANE1    = 5'h04;
    localparam logic [4:0] LANE2    = 5'h08;
    localparam logic [4:0] LANE3    = 5'h0C;
    localparam logic [4:0] CTRL_OFF = 5'h10;

    localparam int CTRL_INC_EN  = 0;
    localparam int CTRL_STEP_LO = 1;
    localparam int CTRL_STEP_HI = 2;
    localparam int CTRL_W       = 3;

    // The lane whose write commits the staged address depends on the bus width.
    function automatic logic [4:0] top_lane_off(input int dwidth);
        case (dwidth)
            32:      return LANE0;
            16:      return LANE1;
            default: return LANE3;
        endcase
    endfunction

endpackage

// File: rtl/coreapb3_iaddr_chan.sv
// One channel: committed address, lane staging, read snapshot, CTRL and auto-increment.
module coreapb3_iaddr_chan
    import coreapb3_iaddr_pkg::*;
#(
    parameter int APB_DWIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lane_wr,
    input  logic                  i_lane_top,
    input  logic [1:0]            i_lane_idx,
    input  logic                  i_ctrl_wr,
    input  logic                  i_rd_snap,
    input  logic [APB_DWIDTH-1:0] i_wdata,
    input  logic                  i_adv,
    output logic [31:0]           o_iaddr,
    output logic [31:0]           o_hold,
    output logic [CTRL_W-1:0]     o_ctrl,
    output logic                  o_wrap
);

    localparam int NLANES = 32 / APB_DWIDTH;

    logic [31:0]       r_iaddr;
    logic [31:0]       r_stage;
    logic [31:0]       r_hold;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_wrap;
    logic [31:0]       w_merged;
    logic [31:0]       w_step;
    logic [32:0]       w_sum;
    logic              w_commit;

    always_comb begin
        w_merged = r_stage;
        for (int k = 0; k < NLANES; k++) begin
            if (i_lane_idx == 2'(k)) begin
                w_merged[k*APB_DWIDTH +: APB_DWIDTH] = i_wdata;
            end
        end
    end

    assign w_step   = 32'd1 << r_ctrl[CTRL_STEP_HI:CTRL_STEP_LO];
    assign w_sum    = {1'b0, r_iaddr} + {1'b0, w_step};
    assign w_commit = i_lane_wr & i_lane_top;

    // A commit in the same cycle as an advance wins and suppresses the wrap pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_iaddr <= '0;
            r_stage <= '0;
            r_hold  <= '0;
            r_ctrl  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_iaddr <= w_merged;
                r_wrap  <= 1'b0;
            end else if (i_adv && r_ctrl[CTRL_INC_EN]) begin
                r_iaddr <= w_sum[31:0];
                r_wrap  <= w_sum[32];
            end else begin
                r_wrap  <= 1'b0;
            end
            if (i_lane_wr && !i_lane_top) begin
                r_stage <= w_merged;
            end
            if (i_ctrl_wr) begin
                r_ctrl <= i_wdata[CTRL_W-1:0];
            end
            if (i_rd_snap) begin
                r_hold <= r_iaddr;
            end
        end
    end

    assign o_iaddr = r_iaddr;
    assign o_hold  = r_hold;
    assign o_ctrl  = r_ctrl;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/coreapb3_iaddr_bank.sv
// APB3 slave with NUM_CH indirect-address registers: decode, error response and read mux.
module coreapb3_iaddr_bank
    import coreapb3_iaddr_pkg::*;
#(
    parameter int APB_DWIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int ADDR_BITS  = 12
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_BITS-1:0]  PADDR,
    input  logic [APB_DWIDTH-1:0] PWDATA,
    output logic [APB_DWIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [NUM_CH-1:0]     IADDR_ADV,
    output logic [NUM_CH*32-1:0]  IADDR,
    output logic [NUM_CH-1:0]     IADDR_WRAP
);

    localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int         NLANES   = 32 / APB_DWIDTH;
    localparam logic [4:0] TOP_OFF  = top_lane_off(APB_DWIDTH);
    localparam logic [1:0] TOP_LANE = TOP_OFF[3:2];

    logic [4:0]            w_off;
    logic [CH_W-1:0]       w_ch;
    logic [1:0]            w_lane_idx;
    logic                  w_upper_nz;
    logic                  w_ch_bad;
    logic                  w_is_lane;
    logic                  w_is_ctrl;
    logic                  w_err;
    logic                  w_access;
    logic                  w_wr;
    logic                  w_rd_snap;
    logic [NUM_CH-1:0]     w_ch_hit;
    logic [31:0]           w_iaddr_arr [NUM_CH];
    logic [31:0]           w_hold_arr  [NUM_CH];
    logic [CTRL_W-1:0]     w_ctrl_arr  [NUM_CH];
    logic [31:0]           w_sel_iaddr;
    logic [31:0]           w_sel_hold;
    logic [CTRL_W-1:0]     w_sel_ctrl;
    logic [31:0]           w_src;
    logic [APB_DWIDTH-1:0] w_lane_rd;

    assign w_off      = PADDR[4:0];
    assign w_ch       = PADDR[5 +: CH_W];
    assign w_lane_idx = w_off[3:2];

    generate
        if (ADDR_BITS > 5 + CH_W) begin : g_upper
            assign w_upper_nz = |PADDR[ADDR_BITS-1:5+CH_W];
        end else begin : g_no_upper
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    assign w_ch_bad  = (32'(w_ch) >= 32'(NUM_CH));
    assign w_is_lane = !w_off[4] && (w_off[1:0] == 2'b00) && (w_lane_idx <= TOP_LANE);
    assign w_is_ctrl = (w_off == CTRL_OFF);
    assign w_err     = w_upper_nz | w_ch_bad | !(w_is_lane | w_is_ctrl);
    assign w_access  = PSEL & PENABLE;
    assign w_wr      = w_access & PWRITE & !w_err;
    assign w_rd_snap = w_access & !PWRITE & !w_err & w_is_lane & (w_lane_idx == 2'd0);

    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & w_err;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            assign w_ch_hit[c] = (w_ch == CH_W'(c));

            coreapb3_iaddr_chan #(
                .APB_DWIDTH (APB_DWIDTH)
            ) u_chan (
                .i_clk      (PCLK),
                .i_rst_n    (PRESETN),
                .i_lane_wr  (w_wr & w_is_lane & w_ch_hit[c]),
                .i_lane_top (w_lane_idx == TOP_LANE),
                .i_lane_idx (w_lane_idx),
                .i_ctrl_wr  (w_wr & w_is_ctrl & w_ch_hit[c]),
                .i_rd_snap  (w_rd_snap & w_ch_hit[c]),
                .i_wdata    (PWDATA),
                .i_adv      (IADDR_ADV[c]),
                .o_iaddr    (w_iaddr_arr[c]),
                .o_hold     (w_hold_arr[c]),
                .o_ctrl     (w_ctrl_arr[c]),
                .o_wrap     (IADDR_WRAP[c])
            );

            assign IADDR[32*c +: 32] = w_iaddr_arr[c];
        end
    endgenerate

    // Lane 0 reads the live address; higher lanes read the snapshot taken on the lane-0 read.
    always_comb begin
        w_sel_iaddr = '0;
        w_sel_hold  = '0;
        w_sel_ctrl  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_hit[i]) begin
                w_sel_iaddr = w_iaddr_arr[i];
                w_sel_hold  = w_hold_arr[i];
                w_sel_ctrl  = w_ctrl_arr[i];
            end
        end
        w_src     = (w_lane_idx == 2'd0) ? w_sel_iaddr : w_sel_hold;
        w_lane_rd = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (w_lane_idx == 2'(k)) begin
                w_lane_rd = w_src[k*APB_DWIDTH +: APB_DWIDTH];
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && !w_err) begin
            PRDATA = w_is_ctrl ? {{(APB_DWIDTH-CTRL_W){1'b0}}, w_sel_ctrl} : w_lane_rd;
        end
    end

endmodule
